// File: rtl/fp_add_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_norm_round
// Purpose  : Significand add/sub, one-bit-per-cycle normalize and
//            round-to-nearest-even stage of a floating-point adder.
// Revision : 1.0  initial release
// ============================================================================
module fp_add_norm_round #(
    parameter int N   = 23,
    parameter int EXP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP-1:0]   in_exp,
    input  logic [N-1:0]     in_big_mant,
    input  logic [N-1:0]     in_small_mant,
    input  logic             in_small_hidden,
    input  logic             in_R,
    input  logic             in_S,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP+N:0]   out_result,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam logic [EXP-1:0] EXP_ONES = '1;
    localparam logic [EXP-1:0] EXP_ONE  = EXP'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic             sign_q;
    logic             sub_q;
    logic [EXP-1:0]   exp_q;
    logic [N-1:0]     big_q;
    logic [N+2:0]     small_q;   // {hidden, fraction, R, S}
    logic [N+3:0]     w_q;       // {carry, hidden, fraction, G, St}

    logic [N+3:0]     sum_d;
    logic [EXP-1:0]   exp_inc_d;
    logic             rnd_up_d;
    logic [N+1:0]     rnd_m_d;
    logic [N-1:0]     rnd_frac_d;
    logic [EXP-1:0]   rnd_exp_d;
    logic             rnd_hid_d;
    logic             rnd_ovf_d;

    assign in_ready = (state_q == S_IDLE);

    always_comb begin
        sum_d     = sub_q ? ({2'b01, big_q, 2'b00} - {1'b0, small_q})
                          : ({2'b01, big_q, 2'b00} + {1'b0, small_q});
        exp_inc_d = exp_q + EXP_ONE;
        rnd_up_d  = w_q[1] & (w_q[0] | w_q[2]);
        rnd_m_d   = {1'b0, w_q[N+2:2]} + {{(N+1){1'b0}}, rnd_up_d};
        if (rnd_m_d[N+1]) begin
            // Rounding carried past the hidden bit: renormalize right by one.
            rnd_frac_d = rnd_m_d[N:1];
            rnd_exp_d  = exp_inc_d;
            rnd_hid_d  = 1'b1;
        end else begin
            rnd_frac_d = rnd_m_d[N-1:0];
            rnd_exp_d  = exp_q;
            rnd_hid_d  = rnd_m_d[N];
        end
        rnd_ovf_d = rnd_hid_d && (rnd_exp_d == EXP_ONES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            sign_q       <= 1'b0;
            sub_q        <= 1'b0;
            exp_q        <= '0;
            big_q        <= '0;
            small_q      <= '0;
            w_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q       <= in_sign;
                        sub_q        <= in_sub;
                        exp_q        <= in_exp;
                        big_q        <= in_big_mant;
                        small_q      <= {in_small_hidden, in_small_mant, in_R, in_S};
                        out_overflow <= 1'b0;
                        out_zero     <= 1'b0;
                        state_q      <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (sum_d == '0) begin
                        out_result <= '0;
                        out_zero   <= 1'b1;
                        out_valid  <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (sum_d[N+3]) begin
                        // Carry out: shift right, fold the lost bit into sticky.
                        w_q   <= {1'b0, sum_d[N+3:2], sum_d[1] | sum_d[0]};
                        exp_q <= exp_inc_d;
                        if (exp_inc_d == EXP_ONES) begin
                            out_result   <= {sign_q, EXP_ONES, {N{1'b0}}};
                            out_overflow <= 1'b1;
                            out_valid    <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_NORM;
                        end
                    end else begin
                        w_q     <= sum_d;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    // Stop at exp==1 so the result degrades into a subnormal.
                    if (w_q[N+2] || (exp_q <= EXP_ONE)) begin
                        state_q <= S_ROUND;
                    end else begin
                        w_q   <= w_q << 1;
                        exp_q <= exp_q - EXP_ONE;
                    end
                end
                S_ROUND: begin
                    if (rnd_ovf_d) begin
                        out_result <= {sign_q, EXP_ONES, {N{1'b0}}};
                    end else begin
                        out_result <= {sign_q, (rnd_hid_d ? rnd_exp_d : {EXP{1'b0}}), rnd_frac_d};
                    end
                    out_overflow <= rnd_ovf_d;
                    out_valid    <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_add_norm_round.md
Name: fp_add_norm_round

Overview:
Downstream stage of the floating-point adder's alignment right-shifter. It takes the larger operand's exponent and fraction, the aligned smaller fraction with its round (R) and sticky (S) bits, and the effective operation. It adds or subtracts the significands, normalizes one bit per cycle, rounds to nearest-even and emits a packed IEEE-754-style result. Both sides use a valid/ready handshake; the block holds one operation at a time.

Parameters:
N, 23, fraction width (hidden bit excluded)
EXP, 8, exponent width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept (IDLE only)
in_sign  input  1  result sign (sign of larger operand)
in_exp  input  EXP  larger operand's biased exponent
in_big_mant  input  N  larger operand fraction (hidden 1 implied)
in_small_mant  input  N  aligned smaller fraction (shifter output)
in_small_hidden  input  1  1 = exponents equal (hidden 1 not shifted in), else 0
in_R  input  1  round bit from shifter
in_S  input  1  sticky bit from shifter
in_sub  input  1  1 = effective subtraction (big minus small)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  1+EXP+N  {sign, exponent, fraction}
out_overflow  output  1  result is infinity from overflow
out_zero  output  1  exact zero result

Behaviour:
- Reset (sync, highest priority, any state incl. mid-operation): state=IDLE, out_valid=0, out_result=0, out_overflow=0, out_zero=0; in_ready=1 the cycle after reset deasserts.
- in_ready = (state==IDLE), combinational from state. Accept on in_valid&in_ready: register all inputs, go ADD.
- Working significand W, width N+4: {carry, hidden, fraction[N-1:0], G, St}.
- ADD (1 cycle): big={0,1,in_big_mant,0,0}; small={0,in_small_hidden,in_small_mant,in_R,in_S}; W=big+small or big-small (upstream guarantees big>=small).
  - W==0: result {0, 0, 0}, out_zero=1, go DONE.
  - carry set: W>>=1 with St|=shifted-out bit, exp+1; if exp reaches all-ones: result {sign, all-ones, 0}, out_overflow=1, go DONE.
  - else go NORM.
- NORM (one left shift per cycle): if hidden==1 or exp==1 -> ROUND (no shift this cycle); else W<<=1, exp-1, stay. k shifts cost k+1 cycles.
- ROUND (1 cycle): lsb=W[2], g=W[1], s=W[0]; round up iff g&(s|lsb). Add 1 at lsb; if fraction overflows past hidden, shift right 1, exp+1; if exp becomes all-ones -> infinity, out_overflow=1. Exponent field = hidden ? exp : 0 (subnormal); a subnormal rounding up into hidden gives exp field 1. Register out_result, go DONE.
- DONE: out_valid=1; out_result and flags stable until out_valid&out_ready, then IDLE, out_valid=0 next cycle. No new accept in DONE.
- Latency from accept edge to out_valid high: 1 (zero/overflow in ADD), else 3+k.
- out_zero / out_overflow cleared on accept of the next operation.

Test Plan:
- 1.0+1.0: exp=127, big=0, small=0, hidden=1, R=S=0, sub=0 -> 0x40000000 after 3 cycles, flags 0.
- 1.0-1.0: same operands with sub=1 -> 0x00000000, out_zero=1, latency 1.
- 1.5-1.25: exp=127, big=0x400000, small=0x200000, hidden=1, sub=1 -> two normalize shifts, 0x3E800000, latency 5.
- Round tie: exp=127, big=0, small=0, hidden=0, R=1, S=0, sub=0 -> 0x3F800000; same with S=1 -> 0x3F800001.
- Overflow: exp=254, big=0x7FFFFF, small=0x7FFFFF, hidden=1, sub=0 -> 0x7F800000, out_overflow=1, latency 1.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> out_result stable, in_ready=0; assert reset during NORM -> next cycle IDLE, out_valid=0, in_ready=1.
